// File: rtl/card_deck_manager_pkg.sv
// Shared constants, state type and helpers for the board draw pile.
// Tile codes: 0..51 = colour*13+(num-1), 52 = joker, 6'h3F = no tile.
package card_deck_manager_pkg;

  localparam int         DECK_CODES = 53;
  localparam logic [5:0] CARD_JOKER = 6'd52;
  localparam logic [5:0] CARD_NONE  = 6'h3F;
  localparam logic [6:0] DECK_SIZE  = 7'd106;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Folds a raw 6-bit random value into the code range 0..52.
  function automatic logic [5:0] fold_code(input logic [5:0] raw);
    return (raw > CARD_JOKER) ? raw - 6'd53 : raw;
  endfunction

endpackage

// File: rtl/card_deck_manager_lfsr16.sv
// Free-running 16-bit Fibonacci LFSR, taps 16,14,13,11.
// reseed reloads the seed synchronously so paired boards stay in lockstep.
module card_deck_manager_lfsr16 (
  input  logic        clk,
  input  logic        rst,
  input  logic        reseed,
  input  logic [15:0] seed,
  output logic [15:0] q
);

  logic [15:0] q_reg;
  logic        fb;

  assign fb = q_reg[15] ^ q_reg[13] ^ q_reg[12] ^ q_reg[10];
  assign q  = q_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_reg <= seed;
    end else if (reseed) begin
      q_reg <= seed;
    end else begin
      q_reg <= {q_reg[14:0], fb};
    end
  end

endmodule

// File: rtl/card_deck_manager.sv
// Authoritative 106-tile draw pile with pseudo-random linear-probe selection.
// Define DECK_RETURN_EN to accept tiles returned to the pile.
module card_deck_manager
  import card_deck_manager_pkg::*;
#(
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       interboard_rst,
  input  logic       draw_req,
  output logic       draw_ready,
  output logic       draw_valid,
  output logic [5:0] draw_card,
  output logic       deck_empty,
  output logic [6:0] remaining,
  input  logic       return_en,
  input  logic [5:0] return_card,
  output logic       return_err
);

  logic [1:0]  cnt_reg [0:DECK_CODES-1];
  state_t      state_reg;
  logic [5:0]  idx_reg;
  logic [5:0]  card_reg;
  logic [6:0]  remaining_reg;
  logic        ready_reg;
  logic        valid_reg;
  logic        err_reg;
  logic [15:0] lfsr_q;
  logic        ret_ok;
  logic        ret_err;
  logic        unused_bits;

  card_deck_manager_lfsr16 u_lfsr (
    .clk    (clk),
    .rst    (rst),
    .reseed (interboard_rst),
    .seed   (LFSR_SEED),
    .q      (lfsr_q)
  );

`ifdef DECK_RETURN_EN
  always_comb begin
    ret_ok = 1'b0;
    if (return_en && (state_reg == ST_IDLE) && (return_card <= CARD_JOKER)) begin
      ret_ok = (cnt_reg[return_card] != 2'd2);
    end
    ret_err = return_en && !ret_ok;
  end
  assign unused_bits = ^lfsr_q[15:6];
`else
  assign ret_ok      = 1'b0;
  assign ret_err     = 1'b0;
  assign unused_bits = ^{lfsr_q[15:6], return_en, return_card};
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DECK_CODES; i++) cnt_reg[i] <= 2'd2;
      remaining_reg <= DECK_SIZE;
      state_reg     <= ST_IDLE;
      idx_reg       <= 6'd0;
      card_reg      <= 6'd0;
      ready_reg     <= 1'b1;
      valid_reg     <= 1'b0;
      err_reg       <= 1'b0;
    end else if (interboard_rst) begin
      for (int i = 0; i < DECK_CODES; i++) cnt_reg[i] <= 2'd2;
      remaining_reg <= DECK_SIZE;
      state_reg     <= ST_IDLE;
      idx_reg       <= 6'd0;
      card_reg      <= 6'd0;
      ready_reg     <= 1'b1;
      valid_reg     <= 1'b0;
      err_reg       <= 1'b0;
    end else begin
      valid_reg <= 1'b0;
      err_reg   <= ret_err;
      case (state_reg)
        ST_IDLE: begin
          // A return lands before a same-cycle draw, so the scan sees it.
          if (ret_ok) begin
            cnt_reg[return_card] <= cnt_reg[return_card] + 2'd1;
            remaining_reg        <= remaining_reg + 7'd1;
          end
          if (draw_req) begin
            ready_reg <= 1'b0;
            if ((remaining_reg != 7'd0) || ret_ok) begin
              state_reg <= ST_SCAN;
              idx_reg   <= fold_code(lfsr_q[5:0]);
            end else begin
              state_reg <= ST_DONE;
              card_reg  <= CARD_NONE;
              valid_reg <= 1'b1;
            end
          end
        end
        ST_SCAN: begin
          if (cnt_reg[idx_reg] != 2'd0) begin
            cnt_reg[idx_reg] <= cnt_reg[idx_reg] - 2'd1;
            remaining_reg    <= remaining_reg - 7'd1;
            card_reg         <= idx_reg;
            state_reg        <= ST_DONE;
            valid_reg        <= 1'b1;
          end else begin
            idx_reg <= (idx_reg == CARD_JOKER) ? 6'd0 : idx_reg + 6'd1;
          end
        end
        ST_DONE: begin
          state_reg <= ST_IDLE;
          ready_reg <= 1'b1;
        end
        default: begin
          state_reg <= ST_IDLE;
          ready_reg <= 1'b1;
        end
      endcase
    end
  end

  assign draw_ready = ready_reg;
  assign draw_valid = valid_reg;
  assign draw_card  = card_reg;
  assign remaining  = remaining_reg;
  assign deck_empty = (remaining_reg == 7'd0);
  assign return_err = err_reg;

endmodule

// File: tb/tb_card_deck_manager.sv
// Randomized bench for card_deck_manager against a per-code count model of the pile.
module tb_card_deck_manager;

  logic       clk = 1'b0;
  logic       rst;
  logic       interboard_rst;
  logic       draw_req;
  logic       draw_ready;
  logic       draw_valid;
  logic [5:0] draw_card;
  logic       deck_empty;
  logic [6:0] remaining;
  logic       return_en;
  logic [5:0] return_card;
  logic       return_err;

  int total = 0;
  int bad   = 0;
  int model_cnt [53];
  int seen      [53];
  int model_rem;

  card_deck_manager dut (
    .clk            (clk),
    .rst            (rst),
    .interboard_rst (interboard_rst),
    .draw_req       (draw_req),
    .draw_ready     (draw_ready),
    .draw_valid     (draw_valid),
    .draw_card      (draw_card),
    .deck_empty     (deck_empty),
    .remaining      (remaining),
    .return_en      (return_en),
    .return_card    (return_card),
    .return_err     (return_err)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", tag, got, want);
    end
  endtask

  task automatic model_refill();
    for (int i = 0; i < 53; i++) begin
      model_cnt[i] = 2;
      seen[i]      = 0;
    end
    model_rem = 106;
  endtask

  // One draw; lat counts clock edges from the request edge up to the edge that raises draw_valid.
  task automatic draw_and_check(output logic [5:0] card);
    int lat;
    bit legal;
    @(negedge clk);
    draw_req = 1'b1;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    draw_req = 1'b0;
    while (!draw_valid && lat < 60) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    check_val("draw_valid_seen", int'(draw_valid), 1);
    card = draw_card;
    if (model_rem == 0) begin
      check_val("empty_card", int'(card), 63);
    end else begin
      legal = (card <= 6'd52) && (model_cnt[card] > 0);
      check_val("card_legal", int'(legal), 1);
      check_val("latency_2_54", int'(lat >= 2 && lat <= 54), 1);
      if (legal) begin
        model_cnt[card]--;
        seen[card]++;
      end
      model_rem--;
    end
    @(posedge clk);
    @(negedge clk);
    $display("draw card=%0d lat=%0d remaining=%0d", card, lat, remaining);
    check_val("remaining", int'(remaining), model_rem);
    check_val("deck_empty", int'(deck_empty), int'(model_rem == 0));
    check_val("ready_after", int'(draw_ready), 1);
    check_val("valid_pulse", int'(draw_valid), 0);
  endtask

  task automatic return_and_check(input logic [5:0] c);
    int want_err;
    want_err = 0;
`ifdef DECK_RETURN_EN
    if (c <= 6'd52 && model_cnt[c] < 2) begin
      model_cnt[c]++;
      model_rem++;
    end else begin
      want_err = 1;
    end
`endif
    @(negedge clk);
    return_en   = 1'b1;
    return_card = c;
    @(posedge clk);
    @(negedge clk);
    return_en = 1'b0;
    $display("return card=%0d err=%0d remaining=%0d", c, return_err, remaining);
    check_val("return_err", int'(return_err), want_err);
    check_val("return_remaining", int'(remaining), model_rem);
    @(posedge clk);
    @(negedge clk);
    check_val("return_err_pulse", int'(return_err), 0);
  endtask

  initial begin
    logic [5:0] card;
    int vcount;
    rst            = 1'b1;
    interboard_rst = 1'b0;
    draw_req       = 1'b0;
    return_en      = 1'b0;
    return_card    = 6'd0;
    model_refill();

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_val("rst_card", int'(draw_card), 0);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("rst_remaining", int'(remaining), 106);
    check_val("rst_ready", int'(draw_ready), 1);
    check_val("rst_empty", int'(deck_empty), 0);
    check_val("rst_valid", int'(draw_valid), 0);
    check_val("rst_err", int'(return_err), 0);

    // Drain the whole pile with random idle gaps; the last draw has one tile left and may wrap.
    for (int n = 0; n < 106; n++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      draw_and_check(card);
    end
    for (int i = 0; i < 53; i++) check_val("seen_twice", seen[i], 2);
    check_val("drained_empty", int'(deck_empty), 1);
    draw_and_check(card);
    check_val("draw107_none", int'(card), 63);

    // Synchronous refill
    @(negedge clk);
    interboard_rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    interboard_rst = 1'b0;
    model_refill();
    check_val("irst_remaining", int'(remaining), 106);
    check_val("irst_empty", int'(deck_empty), 0);

    // Abort mid-scan
    draw_and_check(card);
    @(negedge clk);
    draw_req = 1'b1;
    @(posedge clk);
    @(negedge clk);
    draw_req = 1'b0;
    check_val("scan_not_ready", int'(draw_ready), 0);
    interboard_rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    interboard_rst = 1'b0;
    model_refill();
    check_val("abort_valid", int'(draw_valid), 0);
    check_val("abort_remaining", int'(remaining), 106);
    check_val("abort_ready", int'(draw_ready), 1);
    vcount = 0;
    repeat (5) begin
      @(posedge clk);
      @(negedge clk);
      if (draw_valid) vcount++;
    end
    check_val("abort_no_valid", vcount, 0);

    // Returns: valid returns after draws, an out-of-range code and a full code
    for (int n = 0; n < 6; n++) begin
      draw_and_check(card);
      return_and_check(card);
    end
    return_and_check(6'd53);
    for (int i = 0; i < 53; i++) begin
      if (model_cnt[i] == 2) begin
        return_and_check(6'(i));
        break;
      end
    end
    for (int n = 0; n < 6; n++) begin
      draw_and_check(card);
      return_and_check(6'($urandom_range(0, 57)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
